// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 16 x 16-bit general-purpose register file.
package reg_file_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;

  typedef logic [DATA_W-1:0] reg_word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_cell.sv
// One register-file word: synchronous clear with priority over the load enable.
module reg_cell
  import reg_file_pkg::*;
(
  input  logic      CLK,
  input  logic      Reset,
  input  logic      En,
  input  reg_word_t D,
  output reg_word_t Q
);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      Q <= '0;
    end else if (En) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/reg_file_16b16.sv
// 16 x 16-bit register file: one synchronous write port, two combinational read ports.
module reg_file_16b16
  import reg_file_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Write,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [ADDR_W-1:0] ReadAddrA,
  input  logic [ADDR_W-1:0] ReadAddrB,
  output logic [DATA_W-1:0] ReadDataA,
  output logic [DATA_W-1:0] ReadDataB
);

  logic [NREGS-1:0] writeEn;
  reg_word_t        regQ [NREGS];

  // One-hot write select; all enables stay low when Write is deasserted.
  always_comb begin
    writeEn = '0;
    if (Write) begin
      writeEn[WriteAddr] = 1'b1;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    reg_cell uCell (
      .CLK   (CLK),
      .Reset (Reset),
      .En    (writeEn[i]),
      .D     (DataIn),
      .Q     (regQ[i])
    );
  end

  // Reads come straight from the cells, so a same-cycle write is not bypassed.
  assign ReadDataA = regQ[ReadAddrA];
  assign ReadDataB = regQ[ReadAddrB];

endmodule

// File: tb/tb_reg_file_16b16.sv
// Directed and randomized bench for reg_file_16b16 against an array-based reference model.
module tb_reg_file_16b16;
  import reg_file_pkg::*;

  logic      CLK = 1'b0;
  logic      Reset = 1'b0;
  reg_word_t DataIn = '0;
  logic      Write = 1'b0;
  reg_addr_t WriteAddr = '0;
  reg_addr_t ReadAddrA = '0;
  reg_addr_t ReadAddrB = '0;
  reg_word_t ReadDataA;
  reg_word_t ReadDataB;

  reg_word_t model [NREGS];
  int nCompared = 0;
  int nMismatched = 0;

  reg_file_16b16 dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .Write     (Write),
    .WriteAddr (WriteAddr),
    .ReadAddrA (ReadAddrA),
    .ReadAddrB (ReadAddrB),
    .ReadDataA (ReadDataA),
    .ReadDataB (ReadDataB)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input reg_word_t observed, input reg_word_t expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, apply the storage rules to the model, then settle.
  task automatic tick();
    @(posedge CLK);
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
    end else if (Write) begin
      model[WriteAddr] = DataIn;
    end
    #1;
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      ReadAddrA = reg_addr_t'(i);
      ReadAddrB = reg_addr_t'(NREGS - 1 - i);
      #1;
      check({tag, "_A"}, ReadDataA, model[i]);
      check({tag, "_B"}, ReadDataB, model[NREGS - 1 - i]);
    end
  endtask

  initial begin
    // Reset wins over a simultaneous write.
    @(posedge CLK); #1;
    Reset = 1'b1; Write = 1'b1; DataIn = 16'hBEEF; WriteAddr = 4'd3;
    tick();
    Reset = 1'b0; Write = 1'b0;
    checkAll("reset");
    ReadAddrA = 4'd3; #1;
    check("reset_reg3", ReadDataA, 16'h0000);

    // Sequential fill: new value visible right after the edge, old neighbour on port B.
    for (int n = 0; n < NREGS; n++) begin
      Write = 1'b1;
      WriteAddr = reg_addr_t'(n);
      DataIn = (n == 0) ? 16'hFFFF : reg_word_t'(n);
      ReadAddrA = reg_addr_t'(n);
      #1;
      check("fill_pre_A", ReadDataA, model[n]);
      tick();
      check("fill_post_A", ReadDataA, (n == 0) ? 16'hFFFF : reg_word_t'(n));
      Write = 1'b0;
      ReadAddrB = reg_addr_t'((n + 1) % NREGS);
      #1;
      check("fill_nextB", ReadDataB, model[(n + 1) % NREGS]);
    end

    // Read of the register being written returns the old value until the edge.
    Write = 1'b1; WriteAddr = 4'd5; ReadAddrA = 4'd5; DataIn = 16'h1234;
    #1;
    check("hazard_pre", ReadDataA, 16'h0005);
    tick();
    check("hazard_post", ReadDataA, 16'h1234);
    Write = 1'b0;

    // No change with Write low.
    DataIn = 16'hAAAA; WriteAddr = 4'd7; ReadAddrA = 4'd7;
    for (int k = 0; k < 4; k++) tick();
    check("hold_reg7", ReadDataA, 16'h0007);

    // Both ports on the same register, then a purely combinational address change.
    ReadAddrA = 4'd15; ReadAddrB = 4'd15; #1;
    check("same_A15", ReadDataA, 16'h000F);
    check("same_B15", ReadDataB, 16'h000F);
    ReadAddrB = 4'd0; #1;
    check("comb_B0", ReadDataB, 16'hFFFF);

    // Randomized traffic including occasional resets.
    for (int k = 0; k < 300; k++) begin
      Reset = ($urandom_range(0, 31) == 0);
      Write = $urandom_range(0, 1) != 0;
      WriteAddr = reg_addr_t'($urandom_range(0, NREGS - 1));
      DataIn = reg_word_t'($urandom);
      ReadAddrA = ($urandom_range(0, 3) == 0) ? WriteAddr : reg_addr_t'($urandom_range(0, NREGS - 1));
      ReadAddrB = reg_addr_t'($urandom_range(0, NREGS - 1));
      #1;
      check("rnd_pre_A", ReadDataA, model[ReadAddrA]);
      check("rnd_pre_B", ReadDataB, model[ReadAddrB]);
      tick();
      check("rnd_post_A", ReadDataA, model[ReadAddrA]);
      check("rnd_post_B", ReadDataB, model[ReadAddrB]);
    end
    Reset = 1'b0; Write = 1'b0;
    checkAll("random_end");

    // Final reset clears everything, register 0 included.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkAll("final_reset");
    ReadAddrA = 4'd0; #1;
    check("final_reg0", ReadDataA, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
